mix_scheduler: RTL and testbench
================================

// Module: mix_scheduler
// PURPOSE
//  Sequencer for the waveform mixing datapath. Once per sample tick it steps a source select
//  through NSRC waveform sources via an external mux, and accumulates the enabled ones into
//  one registered mix sample. The sample goes to the output/DAC stage over a valid/ready
//  handshake. One shared adder replaces a wide parallel sum.
// PARAMETERS
//  NSRC   5   number of waveform sources (square, saw, tri, sine, mem); 2..8
//  W      16  sample width, unsigned
//  SELW   3   width of src_sel; must satisfy 2**SELW >= NSRC
// PORTS
//  clk          in   1          system clock (1 MHz)
//  rst_n        in   1          asynchronous active-low reset
//  sample_tick  in   1          1-cycle pulse requesting a new mix sample
//  src_en       in   NSRC       source enable mask (switches/buttons); bit i enables source i
//  src_sel      out  SELW       index driven to external source mux
//  src_data     in   W          mux output; combinational function of src_sel, same cycle
//  out_data     out  W          mixed sample
//  out_valid    out  1          out_data valid; held until accepted
//  out_ready    in   1          downstream accepts when out_valid && out_ready
//  busy         out  1          high in SCAN or DONE
//  overrun      out  1          1-cycle pulse: sample_tick dropped
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, src_sel=0, acc=0, out_data=0, out_valid=0,
//    busy=0, overrun=0, mask snapshot=0. Takes effect immediately, including mid-scan.
//    An in-flight sample is discarded.
//  - FSM states: IDLE, SCAN, DONE.
//  - IDLE: on sample_tick, snapshot src_en to mask, clear acc, set src_sel=0, go to SCAN.
//  - SCAN: on each edge, if mask[src_sel] then acc += src_data. If src_sel==NSRC-1, go to
//    DONE and load out_data from acc; otherwise src_sel++. src_en changes mid-scan are ignored.
//  - acc width is W+3 bits and cannot overflow for NSRC<=8. Reduction to W bits is given
//    under CONFIGURATION.
//  - DONE: out_valid=1, and out_data stays stable until the handshake. On out_valid &&
//    out_ready, clear out_valid and go to IDLE, with src_sel=0.
//  - Latency: tick sampled at edge E gives out_valid=1 after edge E+NSRC+1.
//  - sample_tick in SCAN, or in DONE without a same-cycle handshake: the tick is dropped,
//    and overrun pulses high for exactly the next cycle.
//  - sample_tick in DONE with a same-cycle handshake: the transfer completes and the tick is
//    accepted. The next state is SCAN, with a fresh snapshot and acc=0. No overrun.
//  - mask==0: the full scan still runs, and out_data=0 is presented with normal latency.
//  - src_sel values >= NSRC are never driven.
// CONFIGURATION
//  MIX_SAT_EN defined: out_data = (acc > 2**W-1) ? {W{1'b1}} : acc[W-1:0]. This is
//    unsigned saturation.
//  MIX_SAT_EN undefined: out_data = acc[W-1:0]. The sum wraps modulo 2**W, with no clamp logic.
// TESTING (NSRC=5, W=16; external mux model returns per-index constants)
//  1. src_en=5'b01100, data[2]=100, data[3]=250. Tick at edge E -> src_sel steps 0..4.
//     out_valid rises after edge E+6 with out_data=350. Hold out_ready=0 for 10 cycles ->
//     out_data stable. Then out_ready=1 -> out_valid=0 next cycle.
//  2. src_en=5'b11111, every source 0xF000 -> MIX_SAT_EN: out_data=0xFFFF.
//     Without MIX_SAT_EN: out_data=(5*0xF000) mod 2**16=0xB000.
//  3. Tick, then a second tick 2 cycles later -> overrun pulses for 1 cycle. Exactly one
//     out_valid assertion, carrying the first sample.
//  4. Sample in DONE; drive sample_tick and out_ready in the same cycle -> transfer, no
//     overrun, state SCAN with src_sel=0. Second out_valid arrives NSRC+1 cycles later.
//  5. src_en=0, tick -> out_data=0, out_valid after 6 edges. Separately, toggle src_en
//     mid-scan -> result uses the snapshot taken at the tick.
//  6. Assert rst_n=0 at src_sel=2 mid-scan -> all outputs reset values asynchronously.
//     After release, the next tick produces a correct full sample.

Source files
------------

// File: rtl/mix_scheduler_if.sv
// rtl/mix_scheduler_if.sv - source-mux and output-sample bus for mix_scheduler
//
// Purpose: groups the external source-mux select/data pair and the mixed
// sample valid/ready handshake into one bundle.
// Signals:
//   src_sel    index driven to the external source mux (scheduler -> mux)
//   src_data   mux output, combinational in src_sel (mux -> scheduler)
//   out_data   mixed sample (scheduler -> DAC stage)
//   out_valid  out_data valid, held until accepted (scheduler -> DAC stage)
//   out_ready  downstream accepts on out_valid && out_ready (DAC stage -> scheduler)
// Modports: master = scheduler side, slave = mux/DAC side.
interface mix_scheduler_if #(
  parameter int W    = 16,
  parameter int SELW = 3
);
  logic [SELW-1:0] src_sel;
  logic [W-1:0]    src_data;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output src_sel,
    input  src_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  src_sel,
    output src_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/mix_scheduler.sv
// rtl/mix_scheduler.sv - time-multiplexed waveform mixer sequencer
//
// Purpose: on each sample_tick, steps src_sel through NSRC sources on an
// external mux and accumulates the enabled ones with one shared adder, then
// presents the mix sample over a valid/ready handshake.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   sample_tick   1-cycle request for a new mix sample
//   src_en        source enable mask, snapshotted when a scan starts
//   bus           mix_scheduler_if.master (src_sel/src_data, out_data/valid/ready)
//   busy          high while scanning or holding a sample
//   overrun       1-cycle pulse when a sample_tick was dropped
// Configuration macro: MIX_SAT_EN (defined: unsigned saturation of the sum to
// W bits; undefined: the sum wraps modulo 2**W).
module mix_scheduler #(
  parameter int NSRC = 5,
  parameter int W    = 16,
  parameter int SELW = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_tick,
  input  logic [NSRC-1:0]     src_en,
  mix_scheduler_if.master     bus,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam int AW = W + 3;

  state_t          state_q, state_nx;
  logic [SELW-1:0] sel_q, sel_nx;
  logic [AW-1:0]   acc_q, acc_nx;
  logic [NSRC-1:0] mask_q, mask_nx;
  logic [W-1:0]    data_q, data_nx;
  logic            valid_q, valid_nx;
  logic            ovr_q, ovr_nx;

  logic [NSRC-1:0] sel_onehot;
  logic            sel_enabled;
  logic            last_src;
  logic [W-1:0]    acc_reduced;

  // One-hot decode avoids a variable bit-select wider than the mask.
  assign sel_onehot  = {{(NSRC-1){1'b0}}, 1'b1} << sel_q;
  assign sel_enabled = |(mask_q & sel_onehot);
  assign last_src    = (sel_q == SELW'(NSRC - 1));

`ifdef MIX_SAT_EN
  assign acc_reduced = (|acc_q[AW-1:W]) ? {W{1'b1}} : acc_q[W-1:0];
`else
  assign acc_reduced = acc_q[W-1:0];
`endif

  always_comb begin
    state_nx = state_q;
    sel_nx   = sel_q;
    acc_nx   = acc_q;
    mask_nx  = mask_q;
    data_nx  = data_q;
    valid_nx = valid_q;
    ovr_nx   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          mask_nx  = src_en;
          acc_nx   = '0;
          sel_nx   = '0;
          state_nx = SCAN;
        end
      end

      SCAN: begin
        if (sel_enabled) begin
          acc_nx = acc_q + {3'b000, bus.src_data};
        end
        if (last_src) begin
          state_nx = DONE;
        end else begin
          sel_nx = sel_q + SELW'(1);
        end
        if (sample_tick) begin
          ovr_nx = 1'b1;
        end
      end

      DONE: begin
        if (!valid_q) begin
          // First DONE cycle: the final addition has landed in acc, so the
          // sample is registered here, which sets the NSRC+1 edge latency.
          data_nx  = acc_reduced;
          valid_nx = 1'b1;
          if (sample_tick) begin
            ovr_nx = 1'b1;
          end
        end else if (bus.out_ready) begin
          valid_nx = 1'b0;
          sel_nx   = '0;
          if (sample_tick) begin
            // Back-to-back: handshake and new scan start on the same edge.
            mask_nx  = src_en;
            acc_nx   = '0;
            state_nx = SCAN;
          end else begin
            state_nx = IDLE;
          end
        end else if (sample_tick) begin
          ovr_nx = 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
        sel_nx   = '0;
        valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      acc_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      sel_q   <= sel_nx;
      acc_q   <= acc_nx;
      mask_q  <= mask_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      ovr_q   <= ovr_nx;
    end
  end

  assign bus.src_sel   = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign busy          = (state_q != IDLE);
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_mix_scheduler.sv
// tb/tb_mix_scheduler.sv - scoreboard bench for mix_scheduler
module tb_mix_scheduler;

  localparam int NSRC = 5;
  localparam int W    = 16;
  localparam int SELW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sample_tick = 1'b0;
  logic [NSRC-1:0] src_en = '0;
  logic            busy;
  logic            overrun;
  logic [W-1:0]    data_tbl [8];

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q [$];

  mix_scheduler_if #(.W(W), .SELW(SELW)) bus ();

  mix_scheduler #(.NSRC(NSRC), .W(W), .SELW(SELW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .src_en      (src_en),
    .bus         (bus.master),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // External mux model: per-index constants, combinational in src_sel.
  always_comb bus.src_data = data_tbl[bus.src_sel];

  // Monitor: every accepted sample is popped from the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sample_unexpected: got out_data=%h, no sample expected", bus.out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL sample_data: got out_data=%h, expected %h", bus.out_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a tick sampled at the next edge E; returns just after E.
  task automatic pulse_tick(input logic [NSRC-1:0] en);
    src_en      = en;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  // From just after E: src_sel walks 0..4, out_valid rises after E+6.
  task automatic check_latency(input string tag);
    for (int i = 0; i < NSRC; i++) begin
      chk({tag, "_sel"}, 32'(bus.src_sel), 32'(i));
      step();
    end
    chk({tag, "_valid_e5"}, 32'(bus.out_valid), 32'd0);
    step();
    chk({tag, "_valid_e6"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic accept(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_valid_clr"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_valid_timeout"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic set_base_tbl();
    data_tbl[0] = 16'd7;
    data_tbl[1] = 16'd9;
    data_tbl[2] = 16'd100;
    data_tbl[3] = 16'd250;
    data_tbl[4] = 16'd33;
    data_tbl[5] = 16'hDEAD;
    data_tbl[6] = 16'hDEAD;
    data_tbl[7] = 16'hDEAD;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    set_base_tbl();

    // Reset state
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_sel", 32'(bus.src_sel), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1: two sources, latency, hold under back-pressure
    exp_q.push_back(16'd350);
    pulse_tick(5'b01100);
    check_latency("t1");
    for (int i = 0; i < 10; i++) begin
      chk("t1_hold_data", 32'(bus.out_data), 32'd350);
      chk("t1_hold_valid", 32'(bus.out_valid), 32'd1);
      step();
    end
    accept("t1");
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: all sources 0xF000, saturated or wrapped
    for (int i = 0; i < NSRC; i++) data_tbl[i] = 16'hF000;
`ifdef MIX_SAT_EN
    exp_q.push_back(16'hFFFF);
`else
    exp_q.push_back(16'hB000);
`endif
    pulse_tick(5'b11111);
    check_latency("t2");
    accept("t2");
    set_base_tbl();

    // 3: second tick mid-scan is dropped with a 1-cycle overrun
    exp_q.push_back(16'd16);
    pulse_tick(5'b00011);
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("t3_overrun_hi", 32'(overrun), 32'd1);
    step();
    chk("t3_overrun_lo", 32'(overrun), 32'd0);
    wait_valid("t3");
    accept("t3");
    for (int i = 0; i < 8; i++) step();
    chk("t3_single_valid", 32'(bus.out_valid), 32'd0);

    // 4: tick and handshake on the same edge in DONE
    exp_q.push_back(16'd7);
    exp_q.push_back(16'd9);
    pulse_tick(5'b00001);
    wait_valid("t4a");
    src_en        = 5'b00010;
    sample_tick   = 1'b1;
    bus.out_ready = 1'b1;
    step();
    sample_tick   = 1'b0;
    bus.out_ready = 1'b0;
    chk("t4_overrun", 32'(overrun), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_valid_clr", 32'(bus.out_valid), 32'd0);
    check_latency("t4");
    accept("t4");

    // 5a: empty mask still scans fully and yields 0
    exp_q.push_back(16'd0);
    pulse_tick(5'b00000);
    check_latency("t5a");
    accept("t5a");

    // 5b: src_en change mid-scan ignored
    exp_q.push_back(16'd100);
    pulse_tick(5'b00100);
    src_en = 5'b11111;
    check_latency("t5b");
    accept("t5b");

    // 6: asynchronous reset mid-scan, sample discarded
    pulse_tick(5'b01100);
    step();
    step();
    chk("t6_sel_before", 32'(bus.src_sel), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sel", 32'(bus.src_sel), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_data", 32'(bus.out_data), 32'd0);
    chk("t6_rst_overrun", 32'(overrun), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    exp_q.push_back(16'd350);
    pulse_tick(5'b01100);
    check_latency("t6");
    accept("t6");

    step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
